// File: rtl/fu_alu_issue_arbiter.sv
// Round-robin issue arbiter that shares one pipelined ALU between NREQ requesters.
// Results are tracked by tag through a fixed-latency shadow pipe into a credit-guarded CDB FIFO.
module fu_alu_issue_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAGW   = 4,
    parameter int LAT    = 2,
    parameter int RDEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [4*NREQ-1:0]      req_ctrl,
    input  logic [32*NREQ-1:0]     req_a,
    input  logic [32*NREQ-1:0]     req_b,
    input  logic [TAGW*NREQ-1:0]   req_tag,
    output logic [NREQ-1:0]        req_grant,
    output logic                   alu_en,
    output logic [3:0]             alu_ctrl,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    input  logic [31:0]            alu_res,
    input  logic                   alu_overflow,
    output logic                   cdb_valid,
    output logic [TAGW-1:0]        cdb_tag,
    output logic [31:0]            cdb_data,
    output logic                   cdb_overflow,
    input  logic                   cdb_ready,
    output logic                   busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int OW = $clog2(RDEPTH + LAT + 2) + 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            alu_en_q, alu_en_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [31:0]     alu_a_q, alu_a_d;
    logic [31:0]     alu_b_q, alu_b_d;
    logic [TAGW-1:0] alu_tag_q, alu_tag_d;

    logic [LAT-1:0]  sh_valid_q, sh_valid_d;
    logic [TAGW-1:0] sh_tag_q [LAT];
    logic [TAGW-1:0] sh_tag_d [LAT];

    logic [TAGW-1:0] fifo_tag_q  [RDEPTH];
    logic [TAGW-1:0] fifo_tag_d  [RDEPTH];
    logic [31:0]     fifo_data_q [RDEPTH];
    logic [31:0]     fifo_data_d [RDEPTH];
    logic [RDEPTH-1:0] fifo_ovf_q, fifo_ovf_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic [OW-1:0]   outstanding;
    logic            issue_ok;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand_idx;
    logic            push;
    logic            pop;

    // Credit check counts the issue register too, so a full FIFO can never be overrun.
    always_comb begin
        outstanding = OW'(count_q) + OW'(alu_en_q);
        for (int k = 0; k < LAT; k++) begin
            outstanding = outstanding + OW'(sh_valid_q[k]);
        end
        issue_ok    = !rst && (outstanding < OW'(RDEPTH));
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (issue_ok && !grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        req_grant = '0;
        if (grant_found) begin
            req_grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        alu_en_d   = grant_found;
        alu_ctrl_d = alu_ctrl_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_tag_d  = alu_tag_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant_found) begin
            for (int k = 0; k < NREQ; k++) begin
                if (PW'(k) == grant_idx) begin
                    alu_ctrl_d = req_ctrl[4*k +: 4];
                    alu_a_d    = req_a[32*k +: 32];
                    alu_b_d    = req_b[32*k +: 32];
                    alu_tag_d  = req_tag[TAGW*k +: TAGW];
                end
            end
            rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // The last shadow stage lines up with the cycle alu_res is valid.
    always_comb begin
        sh_valid_d    = '0;
        sh_valid_d[0] = alu_en_q;
        sh_tag_d[0]   = alu_tag_q;
        for (int k = 1; k < LAT; k++) begin
            sh_valid_d[k] = sh_valid_q[k-1];
            sh_tag_d[k]   = sh_tag_q[k-1];
        end
    end

    always_comb begin
        push        = sh_valid_q[LAT-1];
        pop         = (count_q != '0) && cdb_ready;
        fifo_tag_d  = fifo_tag_q;
        fifo_data_d = fifo_data_q;
        fifo_ovf_d  = fifo_ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_tag_d[wr_ptr_q]  = sh_tag_q[LAT-1];
            fifo_data_d[wr_ptr_q] = alu_res;
            fifo_ovf_d[wr_ptr_q]  = alu_overflow;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            alu_en_q    <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_tag_q   <= '0;
            sh_valid_q  <= '0;
            sh_tag_q    <= '{default: '0};
            fifo_tag_q  <= '{default: '0};
            fifo_data_q <= '{default: '0};
            fifo_ovf_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            alu_en_q    <= alu_en_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_tag_q   <= alu_tag_d;
            sh_valid_q  <= sh_valid_d;
            sh_tag_q    <= sh_tag_d;
            fifo_tag_q  <= fifo_tag_d;
            fifo_data_q <= fifo_data_d;
            fifo_ovf_q  <= fifo_ovf_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign alu_en       = alu_en_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign cdb_valid    = (count_q != '0);
    assign cdb_tag      = fifo_tag_q[rd_ptr_q];
    assign cdb_data     = fifo_data_q[rd_ptr_q];
    assign cdb_overflow = fifo_ovf_q[rd_ptr_q];
    assign busy         = (|sh_valid_q) | cdb_valid | alu_en_q;

endmodule

// File: tb/tb_fu_alu_issue_arbiter.sv
// Bench for fu_alu_issue_arbiter: a fake fixed-latency ALU plus a queue-based
// reference model of arbitration, credits and the result stream, with directed and random phases.
module tb_fu_alu_issue_arbiter;

    localparam int NREQ   = 4;
    localparam int TAGW   = 4;
    localparam int LAT    = 2;
    localparam int RDEPTH = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [4*NREQ-1:0]    req_ctrl;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [TAGW*NREQ-1:0] req_tag;
    logic [NREQ-1:0]      req_grant;
    logic                 alu_en;
    logic [3:0]           alu_ctrl;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [31:0]          alu_res;
    logic                 alu_overflow;
    logic                 cdb_valid;
    logic [TAGW-1:0]      cdb_tag;
    logic [31:0]          cdb_data;
    logic                 cdb_overflow;
    logic                 cdb_ready;
    logic                 busy;

    fu_alu_issue_arbiter #(
        .NREQ(NREQ), .TAGW(TAGW), .LAT(LAT), .RDEPTH(RDEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .req_grant(req_grant),
        .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_overflow(alu_overflow),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_overflow(cdb_overflow), .cdb_ready(cdb_ready), .busy(busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [31:0]     data;
        logic            ovf;
        int              due;
    } ent_t;

    int total = 0;
    int bad   = 0;

    ent_t inflight[$];
    ent_t rfifo[$];
    int   rr = 0;
    int   cyc = 0;
    logic m_en = 1'b0;
    logic [3:0]  m_ctrl = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    logic [NREQ-1:0] obs_grant;
    logic            obs_valid;
    logic [TAGW-1:0] obs_tag;
    logic [31:0]     obs_data;
    logic            obs_ovf;
    logic            obs_busy;

    logic [32:0] alu_hist[$];

    // Reference ALU behaviour: add/sub with signed overflow, and, xor otherwise.
    function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o;
        r = a ^ b;
        o = 1'b0;
        case (c)
            4'd1: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd2: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3: r = a & b;
            default: ;
        endcase
        return {o, r};
    endfunction

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drives one cycle of requester/CDB inputs with fresh random operands.
    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic rdy);
        rst       = r;
        req_valid = v;
        cdb_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_ctrl[4*i +: 4]       = 4'($urandom_range(0, 3));
            req_a[32*i +: 32]        = $urandom;
            req_b[32*i +: 32]        = $urandom;
            req_tag[TAGW*i +: TAGW]  = TAGW'($urandom);
        end
    endtask

    // Samples the DUT mid-cycle, compares against the model, then advances the model over the edge.
    task automatic stepCycle();
        logic [NREQ-1:0] exp_grant;
        int              g_idx;
        int              outstanding;
        logic [32:0]     r;
        ent_t            e;
        @(negedge clk);
        exp_grant   = '0;
        g_idx       = -1;
        outstanding = inflight.size() + rfifo.size();
        if (!rst && outstanding < RDEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[(rr + k) % NREQ]) begin
                    g_idx = (rr + k) % NREQ;
                    break;
                end
            end
        end
        if (g_idx >= 0) exp_grant[g_idx] = 1'b1;

        obs_grant = req_grant;
        obs_valid = cdb_valid;
        obs_tag   = cdb_tag;
        obs_data  = cdb_data;
        obs_ovf   = cdb_overflow;
        obs_busy  = busy;

        checkOutput("grant", req_grant, exp_grant);
        checkOutput("alu_en", alu_en, m_en);
        checkOutput("alu_ctrl", alu_ctrl, m_ctrl);
        checkOutput("alu_a", alu_a, m_a);
        checkOutput("alu_b", alu_b, m_b);
        checkOutput("cdb_valid", cdb_valid, rfifo.size() != 0);
        if (rfifo.size() != 0) begin
            checkOutput("cdb_tag", cdb_tag, rfifo[0].tag);
            checkOutput("cdb_data", cdb_data, rfifo[0].data);
            checkOutput("cdb_ovf", cdb_overflow, rfifo[0].ovf);
        end
        checkOutput("busy", busy, (inflight.size() != 0) || (rfifo.size() != 0));

        if (rst) begin
            inflight.delete();
            rfifo.delete();
            rr     = 0;
            m_en   = 1'b0;
            m_ctrl = '0;
            m_a    = '0;
            m_b    = '0;
        end else begin
            if (rfifo.size() != 0 && cdb_ready) e = rfifo.pop_front();
            while (inflight.size() != 0 && inflight[0].due == cyc) begin
                e = inflight.pop_front();
                rfifo.push_back(e);
            end
            if (g_idx >= 0) begin
                rr     = (g_idx + 1) % NREQ;
                m_en   = 1'b1;
                m_ctrl = req_ctrl[4*g_idx +: 4];
                m_a    = req_a[32*g_idx +: 32];
                m_b    = req_b[32*g_idx +: 32];
                r      = alu_fn(m_ctrl, m_a, m_b);
                e.tag  = req_tag[TAGW*g_idx +: TAGW];
                e.data = r[31:0];
                e.ovf  = r[32];
                e.due  = cyc + 1 + LAT;
                inflight.push_back(e);
            end else begin
                m_en = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int idx;
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    // Fake ALU: presents the result of the inputs seen LAT cycles earlier, garbage when idle.
    initial begin
        alu_res      = '0;
        alu_overflow = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (alu_en) alu_hist.push_back(alu_fn(alu_ctrl, alu_a, alu_b));
            else        alu_hist.push_back({1'($urandom), 32'($urandom)});
            if (alu_hist.size() > LAT) begin
                {alu_overflow, alu_res} = alu_hist[$-LAT];
                void'(alu_hist.pop_front());
            end
        end
    end

    // Directed scenarios first, then a long randomized run against the model.
    initial begin
        int seen;
        int cnt;
        int gi;
        int gseq[$];
        int tseq[$];
        int exp_seq[5];

        exp_seq = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '1; req_ctrl = '0; req_a = '0; req_b = '0; req_tag = '0; cdb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_grant", req_grant, 0);
        checkOutput("rst_alu_en", alu_en, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_cdb_valid", cdb_valid, 0);
        checkOutput("rst_cdb_tag", cdb_tag, 0);
        checkOutput("rst_cdb_data", cdb_data, 0);
        checkOutput("rst_cdb_ovf", cdb_overflow, 0);
        checkOutput("rst_busy", busy, 0);

        $display("[TB] single op");
        applyStimulus(1'b0, 4'b0001, 1'b1);
        req_ctrl[3:0] = 4'd1; req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_tag[TAGW-1:0] = 4'd3;
        stepCycle();
        checkOutput("single_grant", obs_grant, 4'b0001);
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
            if (obs_valid && seen == 0) begin
                seen = 1;
                checkOutput("single_lat", k, 4);
                checkOutput("single_data", obs_data, 12);
                checkOutput("single_tag", obs_tag, 3);
            end
        end
        if (seen == 0) checkOutput("single_lat", 99, 4);

        $display("[TB] overflow flag");
        applyStimulus(1'b0, 4'b0001, 1'b1);
        req_ctrl[3:0] = 4'd1; req_a[31:0] = 32'h7FFF_FFFF; req_b[31:0] = 32'd1;
        stepCycle();
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
            if (obs_valid && seen == 0) begin
                seen = 1;
                checkOutput("ovf_data", obs_data, 32'h8000_0000);
                checkOutput("ovf_flag", obs_ovf, 1);
            end
        end
        if (seen == 0) checkOutput("ovf_seen", 0, 1);

        $display("[TB] round robin");
        applyStimulus(1'b1, '0, 1'b1);
        stepCycle();
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0, '1, 1'b1);
            for (int i = 0; i < NREQ; i++) req_tag[TAGW*i +: TAGW] = TAGW'(i);
            stepCycle();
            gi = onehot_idx(obs_grant);
            if (gi >= 0) gseq.push_back(gi);
            if (obs_valid) tseq.push_back(int'(obs_tag));
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("rr_grant_order", (gseq.size() > i) ? gseq[i] : -1, exp_seq[i]);
            checkOutput("rr_tag_order", (tseq.size() > i) ? tseq[i] : -1, exp_seq[i]);
        end

        $display("[TB] backpressure");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
        end
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, '1, 1'b0);
            stepCycle();
            if (obs_grant != '0) cnt++;
        end
        checkOutput("bp_grants", cnt, RDEPTH);
        checkOutput("bp_full_valid", obs_valid, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, '1, 1'b1);
            stepCycle();
            if (obs_grant != '0 && seen == 0) begin
                seen = 1;
                checkOutput("bp_resume", k, 1);
            end
        end
        if (seen == 0) checkOutput("bp_resume", 99, 1);

        $display("[TB] reset mid-flight");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 4'b0011, 1'b1);
            stepCycle();
        end
        applyStimulus(1'b1, '1, 1'b1);
        stepCycle();
        checkOutput("midrst_grant", obs_grant, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
            if (obs_valid) cnt++;
        end
        checkOutput("midrst_no_cdb", cnt, 0);
        checkOutput("midrst_busy", obs_busy, 0);
        applyStimulus(1'b0, '1, 1'b1);
        stepCycle();
        checkOutput("midrst_next_grant", obs_grant, 4'b0001);

        $display("[TB] random run");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 99) == 0), NREQ'($urandom), ($urandom_range(0, 9) < 6));
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
